// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT frame sequencer.
package fft_pkg;
    localparam int N_PT   = 16;
    localparam int FREQ_W = 4;
    localparam int IDX_W  = $clog2(N_PT);

    typedef enum logic [1:0] {IDLE, FFT_RUN, ANA_RUN, RESULT} state_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_flag_t;
endpackage

// File: rtl/fft_pingpong_buf.sv
// Ping-pong 16-sample sample banks with fill/release flags and drop detection.
// FFT_SEQ_STATS_EN exposes the per-cycle drop strobe for the statistics counters.
module fft_pingpong_buf
    import fft_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_valid,
    input  logic [SAMPLE_W-1:0]        data,
    input  logic                       rel,
    output logic [N_PT*SAMPLE_W-1:0]   frame_out,
    output logic                       rd_full,
    output logic                       overflow
`ifdef FFT_SEQ_STATS_EN
    ,
    output logic                       drop
`endif
);
    logic [1:0][N_PT-1:0][SAMPLE_W-1:0] mem;
    logic [1:0]       flag, flag_n;
    logic             wr_bank, wr_bank_n, rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             accept, last;

    assign accept    = data_valid && (flag[wr_bank] == EMPTY);
    assign last      = accept && (wr_idx == IDX_W'(N_PT - 1));
    assign frame_out = mem[rd_bank];
    assign rd_full   = (flag[rd_bank] == FULL);
`ifdef FFT_SEQ_STATS_EN
    assign drop      = data_valid && !accept;
`endif

    // A filled bank hands the write pointer over as soon as the other bank is
    // (or becomes, on this edge) empty.
    always_comb begin
        flag_n = flag;
        if (rel)  flag_n[rd_bank] = EMPTY;
        if (last) flag_n[wr_bank] = FULL;
        wr_bank_n = wr_bank;
        if (flag_n[wr_bank] == FULL && flag_n[~wr_bank] == EMPTY)
            wr_bank_n = ~wr_bank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            flag     <= {EMPTY, EMPTY};
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_bank][wr_idx] <= data;
                wr_idx               <= wr_idx + IDX_W'(1);
            end
            flag    <= flag_n;
            wr_bank <= wr_bank_n;
            if (rel) rd_bank <= ~rd_bank;
            if (data_valid && !accept) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer: buffers samples, runs FFT then analyzer, returns the peak bin.
// Define FFT_SEQ_STATS_EN to add the frame_cnt / drop_cnt statistics ports.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    input  logic [SAMPLE_W-1:0]      data,
    output logic [N_PT*SAMPLE_W-1:0] frame_out,
    output logic                     fft_start,
    input  logic                     fft_valid,
    output logic                     ana_start,
    input  logic                     ana_done,
    input  logic [FREQ_W-1:0]        ana_freq,
    output logic                     res_valid,
    output logic [FREQ_W-1:0]        res_freq,
    input  logic                     res_ready,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic                     busy
`ifdef FFT_SEQ_STATS_EN
    ,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              drop_cnt
`endif
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       rel, to_hit, cap, ack, rd_full;

`ifdef FFT_SEQ_STATS_EN
    logic drop;
`endif

    fft_pingpong_buf #(.SAMPLE_W(SAMPLE_W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .rel        (rel),
        .frame_out  (frame_out),
        .rd_full    (rd_full),
        .overflow   (overflow)
`ifdef FFT_SEQ_STATS_EN
        ,
        .drop       (drop)
`endif
    );

    assign busy = (state != IDLE);

    // cnt==0 marks the start cycle of each run state; strobes are ignored there.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rel       = 1'b0;
        to_hit    = 1'b0;
        cap       = 1'b0;
        ack       = 1'b0;
        fft_start = 1'b0;
        ana_start = 1'b0;
        case (state)
            IDLE: begin
                if (rd_full) begin
                    state_n = FFT_RUN;
                    cnt_n   = '0;
                end
            end
            FFT_RUN: begin
                fft_start = (cnt == 8'd0);
                cnt_n     = cnt + 8'd1;
                if (cnt != 8'd0 && fft_valid) begin
                    state_n = ANA_RUN;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    state_n = IDLE;
                    rel     = 1'b1;
                    to_hit  = 1'b1;
                end
            end
            ANA_RUN: begin
                ana_start = (cnt == 8'd0);
                cnt_n     = cnt + 8'd1;
                if (cnt != 8'd0 && ana_done) begin
                    state_n = RESULT;
                    rel     = 1'b1;
                    cap     = 1'b1;
                end else if (cnt == TO_LAST) begin
                    state_n = IDLE;
                    rel     = 1'b1;
                    to_hit  = 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_n = IDLE;
                    ack     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid   <= 1'b0;
            res_freq    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (cap) begin
                res_valid <= 1'b1;
                res_freq  <= ana_freq;
            end
            if (ack)    res_valid   <= 1'b0;
            if (to_hit) timeout_err <= 1'b1;
        end
    end

`ifdef FFT_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (ack) frame_cnt <= frame_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed/randomized bench for fft_seq_ctrl with a frame-queue reference model.
// Build with FFT_SEQ_STATS_EN defined to also check frame_cnt / drop_cnt.
module tb_fft_seq_ctrl;
    localparam int SW = 16;
    localparam int TO = 64;

    logic            clk, rst, data_valid, fft_valid, ana_done, res_ready;
    logic [SW-1:0]   data;
    logic [3:0]      ana_freq, res_freq;
    logic [16*SW-1:0] frame_out;
    logic            fft_start, ana_start, res_valid, overflow, timeout_err, busy;
`ifdef FFT_SEQ_STATS_EN
    logic [15:0]     frame_cnt, drop_cnt;
`endif

    fft_seq_ctrl #(.SAMPLE_W(SW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .frame_out(frame_out), .fft_start(fft_start), .fft_valid(fft_valid),
        .ana_start(ana_start), .ana_done(ana_done), .ana_freq(ana_freq),
        .res_valid(res_valid), .res_freq(res_freq), .res_ready(res_ready),
        .overflow(overflow), .timeout_err(timeout_err), .busy(busy)
`ifdef FFT_SEQ_STATS_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int hs_cnt = 0;
    int cidx = 0;
    logic [15:0][SW-1:0] cur;
    logic [16*SW-1:0] q_frames[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepted samples are grouped 16 at a time into expected frames.
    task automatic send(input int n, input bit acc, input bit ramp);
        for (int i = 0; i < n; i++) begin
            logic [SW-1:0] s;
            s = ramp ? SW'(i) : SW'($urandom);
            data = s;
            data_valid = 1'b1;
            if (acc) begin
                cur[cidx] = s;
                cidx++;
                if (cidx == 16) begin
                    q_frames.push_back(cur);
                    cidx = 0;
                end
            end
            step();
        end
        data_valid = 1'b0;
    endtask

    // Plays the FFT core and analyzer for one frame. fft_lat < 0: never answer.
    task automatic run_frame(input int fft_lat, input int ana_lat, input int hold, input bit early);
        logic [3:0] f;
        logic [16*SW-1:0] exp_frame;
        f = 4'($urandom);
        for (int i = 0; i < 300 && !fft_start; i++) step();
        chk("fft_start_seen", fft_start, 1);
        exp_frame = (q_frames.size() > 0) ? q_frames.pop_front() : '0;
        chk("frame_out", frame_out, exp_frame);
        if (fft_lat < 0) begin
            repeat (TO - 1) step();
            chk("timeout_pre_busy", busy, 1);
            chk("timeout_pre_ana", ana_start, 0);
            step();
            chk("timeout_err", timeout_err, 1);
            chk("timeout_idle", busy, 0);
            return;
        end
        fft_valid = early;
        step();
        fft_valid = 1'b0;
        if (early) chk("early_fft_valid_ignored", ana_start, 0);
        repeat (fft_lat - 1) step();
        fft_valid = 1'b1;
        step();
        fft_valid = 1'b0;
        chk("ana_start", ana_start, 1);
        ana_done = early;
        ana_freq = ~f;
        step();
        ana_done = 1'b0;
        if (early) chk("early_ana_done_ignored", res_valid, 0);
        repeat (ana_lat - 1) step();
        ana_done = 1'b1;
        ana_freq = f;
        step();
        ana_done = 1'b0;
        ana_freq = 4'($urandom);
        chk("res_valid", res_valid, 1);
        chk("res_freq", res_freq, f);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", res_valid, 1);
            chk("hold_freq", res_freq, f);
            chk("hold_no_start", fft_start, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        hs_cnt++;
        chk("res_valid_clear", res_valid, 0);
`ifdef FFT_SEQ_STATS_EN
        chk("frame_cnt", frame_cnt, hs_cnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data_valid = 1'b0; data = '0; fft_valid = 1'b0;
        ana_done = 1'b0; ana_freq = '0; res_ready = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_freq", res_freq, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_frame", frame_out, 0);
        rst = 1'b0;

        // single ramp frame, fft_start exactly two edges after the 16th capture
        send(16, 1, 1);
        chk("start_not_yet", fft_start, 0);
        step();
        chk("start_n_plus_2", fft_start, 1);
        chk("frame_lo", frame_out[15:0], 0);
        chk("frame_hi", frame_out[255:240], 15);
        run_frame(5, 3, 10, 0);

        // stray strobes while idle
        fft_valid = 1'b1; ana_done = 1'b1;
        step();
        fft_valid = 1'b0; ana_done = 1'b0;
        step();
        chk("stray_busy", busy, 0);
        chk("stray_res", res_valid, 0);

        // back-to-back frames processed while samples keep streaming
        fork
            send(48, 1, 0);
            repeat (3) run_frame(5, 3, 0, 0);
        join
        chk("b2b_overflow", overflow, 0);

        // overflow: result held while both banks fill, then three extras
        fork
            begin
                send(48, 1, 0);
                send(3, 0, 0);
                chk("ovf_flag", overflow, 1);
                chk("ovf_frame_kept", frame_out, q_frames[0]);
`ifdef FFT_SEQ_STATS_EN
                chk("drop_cnt", drop_cnt, 3);
`endif
            end
            run_frame(5, 3, 40, 0);
        join
        run_frame(4, 2, 0, 0);
        run_frame(6, 4, 0, 0);

        // timeout then a normal frame
        send(16, 1, 0);
        run_frame(-1, 0, 0, 0);
        send(16, 1, 0);
        run_frame(4, 2, 0, 0);
        chk("to_sticky", timeout_err, 1);

        // reset during ANA_RUN with a partial frame in the other bank
        send(16, 1, 0);
        for (int i = 0; i < 300 && !fft_start; i++) step();
        step(); step();
        fft_valid = 1'b1;
        step();
        fft_valid = 1'b0;
        chk("mid_ana_start", ana_start, 1);
        send(5, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_frames.delete();
        cidx = 0;
        hs_cnt = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame", frame_out, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_to", timeout_err, 0);
        chk("mid_rst_res", res_valid, 0);
        ana_done = 1'b1; ana_freq = 4'd9;
        step();
        ana_done = 1'b0;
        chk("late_done_res", res_valid, 0);
        chk("late_done_busy", busy, 0);

        // strobe exactly at the timeout count wins; start-cycle strobes ignored
        send(16, 1, 0);
        chk("post_rst_not_yet", fft_start, 0);
        step();
        chk("post_rst_start", fft_start, 1);
        run_frame(TO - 1, 3, 2, 1);
        chk("boundary_no_timeout", timeout_err, 0);
        chk("boundary_no_ovf", overflow, 0);
`ifdef FFT_SEQ_STATS_EN
        chk("drop_cnt_rst", drop_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Frame sequencer in front of the 16-point FFT core and the `analyze` peak-bin block.
- Collects a stream of signed samples into ping-pong 16-sample banks and presents a stable frame to the FFT.
- Pulses FFT start, waits for `fft_valid`, then pulses analyzer start and waits for `done`.
- Returns the dominant `freq` bin over a valid/ready result port.

Parameters:
- SAMPLE_W, 16, signed sample width.
- TIMEOUT_CYC, 64, maximum cycles allowed in FFT_RUN or ANA_RUN before error; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_valid  in  1  sample strobe.
- data  in  SAMPLE_W  signed input sample.
- frame_out  out  16*SAMPLE_W  frame of the read bank; sample k at bits [k*SAMPLE_W +: SAMPLE_W], k=0 is oldest.
- fft_start  out  1  one-cycle start pulse to the FFT core.
- fft_valid  in  1  FFT result strobe.
- ana_start  out  1  one-cycle start pulse to the analyzer.
- ana_done  in  1  analyzer done strobe.
- ana_freq  in  4  analyzer peak bin, sampled with ana_done.
- res_valid  out  1  result available.
- res_freq  out  4  result bin.
- res_ready  in  1  result consumer ready.
- overflow  out  1  sticky: a sample was dropped.
- timeout_err  out  1  sticky: an FFT or analyzer step timed out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, frame_out 0, both banks EMPTY, wr_bank=0, rd_bank=0, wr_idx=0, state IDLE.
- Bank flags are EMPTY or FULL.
  - A sample is accepted iff data_valid=1 and bank[wr_bank] is EMPTY.
  - An accepted sample is written at wr_idx; wr_idx increments.
  - Otherwise the sample is dropped and overflow is set.
- 16th accepted sample (wr_idx=15):
  - bank[wr_bank] is set FULL and wr_idx wraps to 0 on that edge.
  - If bank[~wr_bank] is EMPTY, wr_bank toggles on the same edge.
  - Otherwise wr_bank toggles on the edge that releases the other bank.
- Release and sample in the same cycle with bank[wr_bank] FULL: the sample is dropped; the release is not bypassed.
- rd_bank alternates strictly 0,1,0,…; it toggles on every release. frame_out = bank[rd_bank] contents, constant while that bank is FULL.
- FSM states: IDLE, FFT_RUN, ANA_RUN, RESULT.
  - IDLE: if bank[rd_bank] is FULL, go to FFT_RUN. fft_start=1 for the first FFT_RUN cycle only. If the 16th sample is captured at edge N, fft_start is high in cycle N+2.
  - FFT_RUN: fft_valid is ignored in the fft_start cycle. On a later fft_valid=1, go to ANA_RUN; ana_start=1 for the first ANA_RUN cycle.
  - ANA_RUN: ana_done is ignored in the ana_start cycle. On a later ana_done=1, capture ana_freq into res_freq, set res_valid, go to RESULT, and release bank[rd_bank] (EMPTY) on that edge.
  - RESULT: res_valid and res_freq hold until res_valid&res_ready; then res_valid clears and the FSM returns to IDLE on that edge.
- Timeout:
  - An 8-bit counter clears on entry to FFT_RUN and on entry to ANA_RUN; it increments each cycle in those states.
  - When counter=TIMEOUT_CYC-1 with no strobe: set timeout_err, release bank[rd_bank], return to IDLE, no result.
  - A strobe arriving in the same cycle as the timeout wins.
- Stray strobes: fft_valid or ana_done outside its state is ignored.
- Reset mid-operation returns everything to reset values on the next edge. Partial frames are discarded.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: FFT_SEQ_STATS_EN.
- With the macro:
  - Adds `frame_cnt` (out, 16): increments on each res_valid&res_ready handshake, wraps.
  - Adds `drop_cnt` (out, 16): increments per dropped sample, saturates at 16'hFFFF.
  - Both reset to 0.
- Without the macro: those ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fft_pkg:
  - N_PT=16.
  - FREQ_W=4.
  - State enum {IDLE, FFT_RUN, ANA_RUN, RESULT}.
  - Bank flag encoding.
- One natural sub-module: fft_pingpong_buf, holding the banks, wr_idx, wr_bank, rd_bank, flags and the overflow/drop logic.
- The FSM, timeout counter and result register stay in the top level.

Test Plan:
- Single frame: 16 samples 0..15, core returns fft_valid at cycle +5 and ana_done(freq=4'd7) at +3 -> fft_start high in cycle N+2; res_valid with res_freq=7; frame_out[15:0]=0 and [255:240]=15.
- Back-to-back: 48 contiguous samples, processing 20 cycles per frame -> three results in order, bank sequence 0,1,0, overflow=0.
- Overflow: both banks full, res_ready=0, 3 extra samples -> overflow=1; with FFT_SEQ_STATS_EN, drop_cnt=3; frame contents unchanged.
- Timeout: fft_valid never asserted, TIMEOUT_CYC=64 -> timeout_err=1 64 cycles after FFT_RUN entry, bank released, next full frame processed normally.
- Backpressure: res_ready low for 10 cycles -> res_valid/res_freq stable; no new fft_start until the handshake completes.
- Mid-operation reset: rst asserted during ANA_RUN -> next cycle all outputs 0 and banks EMPTY; a late ana_done is ignored.
